// File: rtl/ahb_sram_slave_if_pkg.sv
// Shared definitions for the AHB-Lite to SRAM-controller slave bridge:
// FSM encoding, AHB constants and the address-phase legality check.
package ahb_sram_slave_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WDATA    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR1     = 3'd5,
    ST_ERR2     = 3'd6
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Oversized, misaligned or out-of-range accesses are rejected before reaching the SRAM
  function automatic logic access_error(input logic [2:0]  size,
                                        input logic [19:0] addr,
                                        input logic [31:0] mem_bytes);
    logic err;
    err = 1'b0;
    if (size > HSIZE_WORD) begin
      err = 1'b1;
    end else if ((size == HSIZE_HALF) && addr[0]) begin
      err = 1'b1;
    end else if ((size == HSIZE_WORD) && (addr[1:0] != 2'b00)) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
    if ({12'd0, addr} >= mem_bytes) begin
      err = 1'b1;
    end else begin
      err = err;
    end
    return err;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if_if.sv
// Bus bundle between the AHB-Lite fabric / SRAM controller and the bridge.
interface ahb_sram_slave_if_if;
  logic        HSEL;
  logic        HREADYIN;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [19:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        ahbsram_req;
  logic        ahbsram_write;
  logic [2:0]  ahbsram_size;
  logic [19:0] ahbsram_addr;
  logic [31:0] ahbsram_wdata;
  logic        sramahb_ack;
  logic [31:0] sramahb_rdata;
  logic        BUSY;

  modport slave (
    input  HSEL, HREADYIN, HWRITE, HTRANS, HSIZE, HADDR, HWDATA,
    input  sramahb_ack, sramahb_rdata, BUSY,
    output HREADYOUT, HRESP, HRDATA,
    output ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata
  );

  modport master (
    output HSEL, HREADYIN, HWRITE, HTRANS, HSIZE, HADDR, HWDATA,
    output sramahb_ack, sramahb_rdata, BUSY,
    input  HREADYOUT, HRESP, HRDATA,
    input  ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata
  );
endinterface

// File: rtl/ahb_sram_slave_if_ack_timer.sv
// Loadable down-counter bounding how long the bridge waits for an SRAM ack.
module ahb_sram_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(ACK_TIMEOUT + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Reload on WAIT_ACK entry, count down while waiting, saturate at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = W'(ACK_TIMEOUT);
    end else if (en && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the last permitted wait cycle, so the ACK_TIMEOUT-th cycle is the final one
  assign expire = (count_q == W'(1));
endmodule

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave that turns single transfers into one-shot SRAM controller requests.
module ahb_sram_slave_if
  import ahb_sram_slave_if_pkg::*;
#(
  parameter int MEM_BYTES   = 2048,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_sram_slave_if_if.slave   bus
);

  state_e      state_q, state_d;
  logic [19:0] addr_q,  addr_d;
  logic [2:0]  size_q,  size_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_s;
  logic        timer_load_s;
  logic        timer_expire_s;
  logic        in_wait_s;

  assign valid_s = bus.HSEL & bus.HREADYIN &
                   ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
  assign in_wait_s = (state_q == ST_WAIT_ACK);

  // Next-state and request-field capture
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    timer_load_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (!valid_s) begin
          state_d = ST_IDLE;
        end else if (access_error(bus.HSIZE, bus.HADDR, 32'(MEM_BYTES))) begin
          state_d = ST_ERR1;
        end else begin
          addr_d  = bus.HADDR;
          size_d  = bus.HSIZE;
          write_d = bus.HWRITE;
          state_d = bus.HWRITE ? ST_WDATA : ST_ISSUE;
        end
      end
      ST_WDATA: begin
        wdata_d = bus.HWDATA;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.BUSY) begin
          state_d = ST_ISSUE;
        end else begin
          timer_load_s = 1'b1;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // An ack landing in the final timeout cycle still wins
        if (bus.sramahb_ack) begin
          state_d = ST_DONE;
        end else if (timer_expire_s) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= 20'd0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  ahb_sram_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clk    (HCLK),
    .rst    (HRESET),
    .load   (timer_load_s),
    .en     (in_wait_s),
    .expire (timer_expire_s)
  );

  assign bus.HREADYOUT     = !((state_q == ST_WDATA) || (state_q == ST_ISSUE) ||
                               (state_q == ST_WAIT_ACK) || (state_q == ST_ERR1));
  assign bus.HRESP         = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA        = (state_q == ST_DONE) ? bus.sramahb_rdata : 32'd0;
  assign bus.ahbsram_req   = (state_q == ST_ISSUE) && !bus.BUSY;
  assign bus.ahbsram_write = write_q;
  assign bus.ahbsram_size  = size_q;
  assign bus.ahbsram_addr  = addr_q;
  assign bus.ahbsram_wdata = wdata_q;
endmodule

// File: tb/tb_ahb_sram_slave_if.sv
// Directed bench for ahb_sram_slave_if: cycle-exact checks against hand-derived values.
module tb_ahb_sram_slave_if;
  import ahb_sram_slave_if_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ahb_sram_slave_if_if bus();

  ahb_sram_slave_if #(.MEM_BYTES(2048), .ACK_TIMEOUT(15)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  err_size [4];
  logic [19:0] err_addr [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [19:0] ad);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = wr;
    bus.HSIZE  = sz;
    bus.HADDR  = ad;
    tick();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.ahbsram_req} !== 4'b1000) begin
      $display("FAIL reset_resp: got %b want 1000", {bus.HREADYOUT, bus.HRESP, bus.ahbsram_req});
      n_bad++;
    end
    n_cmp++;
    if ({bus.ahbsram_addr, bus.ahbsram_size, bus.ahbsram_write, bus.ahbsram_wdata} !== 56'd0) begin
      $display("FAIL reset_req_fields: got %h want 0",
               {bus.ahbsram_addr, bus.ahbsram_size, bus.ahbsram_write, bus.ahbsram_wdata});
      n_bad++;
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_IDLE;
    tick();
    bus.HTRANS = HTRANS_BUSY;
    tick();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_NONSEQ;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({bus.HREADYOUT, bus.HRESP, bus.ahbsram_req} !== 4'b1000) begin
        $display("FAIL idle_okay[%0d]: got %b want 1000", i, {bus.HREADYOUT, bus.HRESP, bus.ahbsram_req});
        n_bad++;
      end
      tick();
    end
    bus.HTRANS = HTRANS_IDLE;
  endtask

  task automatic test_write();
    addr_phase(1'b1, HSIZE_WORD, 20'h00010);
    bus.HWDATA = 32'hDEADBEEF;
    n_cmp++;
    if ({bus.HREADYOUT, bus.ahbsram_req} !== 2'b00) begin
      $display("FAIL wr_c1: got %b want 00", {bus.HREADYOUT, bus.ahbsram_req});
      n_bad++;
    end
    tick();
    bus.HWDATA = 32'h0;
    n_cmp++;
    if ({bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_write, bus.ahbsram_size, bus.ahbsram_addr}
        !== {1'b0, 1'b1, 1'b1, 3'b010, 20'h00010}) begin
      $display("FAIL wr_c2_req: rdy/req/wr/size/addr got %b %b %b %b %h want 0 1 1 010 00010",
               bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_write, bus.ahbsram_size, bus.ahbsram_addr);
      n_bad++;
    end
    n_cmp++;
    if (bus.ahbsram_wdata !== 32'hDEADBEEF) begin
      $display("FAIL wr_wdata: got %h want deadbeef", bus.ahbsram_wdata);
      n_bad++;
    end
    tick();
    bus.sramahb_ack = 1'b1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_wdata} !== {2'b00, 32'hDEADBEEF}) begin
      $display("FAIL wr_c3: rdy/req/wdata got %b %b %h want 0 0 deadbeef",
               bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_wdata);
      n_bad++;
    end
    tick();
    bus.sramahb_ack = 1'b0;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.ahbsram_req} !== 4'b1000) begin
      $display("FAIL wr_done_c4: got %b want 1000", {bus.HREADYOUT, bus.HRESP, bus.ahbsram_req});
      n_bad++;
    end
    tick();
  endtask

  task automatic test_read();
    addr_phase(1'b0, HSIZE_WORD, 20'h00010);
    n_cmp++;
    if ({bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_write, bus.ahbsram_addr} !== {3'b010, 20'h00010}) begin
      $display("FAIL rd_c1: rdy/req/wr/addr got %b %b %b %h want 0 1 0 00010",
               bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_write, bus.ahbsram_addr);
      n_bad++;
    end
    tick();
    bus.sramahb_ack = 1'b1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.ahbsram_req} !== 2'b00) begin
      $display("FAIL rd_c2: got %b want 00", {bus.HREADYOUT, bus.ahbsram_req});
      n_bad++;
    end
    tick();
    bus.sramahb_ack   = 1'b0;
    bus.sramahb_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {3'b100, 32'hDEADBEEF}) begin
      $display("FAIL rd_c3_data: rdy/resp/rdata got %b %b %h want 1 00 deadbeef",
               bus.HREADYOUT, bus.HRESP, bus.HRDATA);
      n_bad++;
    end
    tick();
    bus.sramahb_rdata = 32'h0;
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) begin
      addr_phase(1'b0, err_size[i], err_addr[i]);
      n_cmp++;
      if ({bus.HREADYOUT, bus.HRESP, bus.ahbsram_req} !== 4'b0010) begin
        $display("FAIL err%0d_first: got %b want 0010", i, {bus.HREADYOUT, bus.HRESP, bus.ahbsram_req});
        n_bad++;
      end
      tick();
      n_cmp++;
      if ({bus.HREADYOUT, bus.HRESP, bus.ahbsram_req} !== 4'b1010) begin
        $display("FAIL err%0d_second: got %b want 1010", i, {bus.HREADYOUT, bus.HRESP, bus.ahbsram_req});
        n_bad++;
      end
      tick();
    end
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.ahbsram_req} !== 4'b1000) begin
      $display("FAIL err_back_idle: got %b want 1000", {bus.HREADYOUT, bus.HRESP, bus.ahbsram_req});
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    // Last legal byte, then a write pipelined into the DONE cycle
    addr_phase(1'b0, HSIZE_BYTE, 20'h007FF);
    n_cmp++;
    if ({bus.ahbsram_req, bus.ahbsram_size, bus.ahbsram_addr} !== {1'b1, 3'b000, 20'h007FF}) begin
      $display("FAIL b2b_rd_req: req/size/addr got %b %b %h want 1 000 007ff",
               bus.ahbsram_req, bus.ahbsram_size, bus.ahbsram_addr);
      n_bad++;
    end
    tick();
    bus.sramahb_ack = 1'b1;
    tick();
    bus.sramahb_ack   = 1'b0;
    bus.sramahb_rdata = 32'h000000A5;
    #1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {3'b100, 32'h000000A5}) begin
      $display("FAIL b2b_rd_done: got %b %b %h want 1 00 000000a5", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
      n_bad++;
    end
    addr_phase(1'b1, HSIZE_HALF, 20'h007FE);
    bus.sramahb_rdata = 32'h0;
    bus.HWDATA        = 32'h00001234;
    n_cmp++;
    if ({bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_write, bus.ahbsram_addr} !== {3'b001, 20'h007FE}) begin
      $display("FAIL b2b_wr_c1: rdy/req/wr/addr got %b %b %b %h want 0 0 1 007fe",
               bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_write, bus.ahbsram_addr);
      n_bad++;
    end
    tick();
    n_cmp++;
    if ({bus.ahbsram_req, bus.ahbsram_size, bus.ahbsram_wdata} !== {1'b1, 3'b001, 32'h00001234}) begin
      $display("FAIL b2b_wr_req: req/size/wdata got %b %b %h want 1 001 00001234",
               bus.ahbsram_req, bus.ahbsram_size, bus.ahbsram_wdata);
      n_bad++;
    end
    tick();
    bus.sramahb_ack = 1'b1;
    tick();
    bus.sramahb_ack = 1'b0;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP} !== 3'b100) begin
      $display("FAIL b2b_wr_done: got %b want 100", {bus.HREADYOUT, bus.HRESP});
      n_bad++;
    end
    tick();
  endtask

  task automatic test_busy();
    int reqs;
    reqs     = 0;
    bus.BUSY = 1'b1;
    addr_phase(1'b0, HSIZE_WORD, 20'h00020);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.HREADYOUT, bus.ahbsram_req} !== 2'b00) begin
        $display("FAIL busy_hold[%0d]: got %b want 00", i, {bus.HREADYOUT, bus.ahbsram_req});
        n_bad++;
      end
      tick();
    end
    bus.BUSY = 1'b0;
    #1;
    if (bus.ahbsram_req === 1'b1) reqs++;
    n_cmp++;
    if (bus.HREADYOUT !== 1'b0) begin
      $display("FAIL busy_release_rdy: got %b want 0", bus.HREADYOUT);
      n_bad++;
    end
    tick();
    bus.sramahb_ack = 1'b1;
    if (bus.ahbsram_req === 1'b1) reqs++;
    n_cmp++;
    if (reqs !== 1) begin
      $display("FAIL busy_req_pulses: got %0d want 1", reqs);
      n_bad++;
    end
    tick();
    bus.sramahb_ack   = 1'b0;
    bus.sramahb_rdata = 32'h12345678;
    #1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {3'b100, 32'h12345678}) begin
      $display("FAIL busy_done: got %b %b %h want 1 00 12345678", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
      n_bad++;
    end
    tick();
    bus.sramahb_rdata = 32'h0;
  endtask

  task automatic test_timeout();
    addr_phase(1'b0, HSIZE_WORD, 20'h00030);
    tick();
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if ({bus.HREADYOUT, bus.HRESP, bus.ahbsram_req} !== 4'b0000) begin
        $display("FAIL to_wait[%0d]: got %b want 0000", i, {bus.HREADYOUT, bus.HRESP, bus.ahbsram_req});
        n_bad++;
      end
      tick();
    end
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP} !== 3'b001) begin
      $display("FAIL to_err1: got %b want 001", {bus.HREADYOUT, bus.HRESP});
      n_bad++;
    end
    tick();
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP} !== 3'b101) begin
      $display("FAIL to_err2: got %b want 101", {bus.HREADYOUT, bus.HRESP});
      n_bad++;
    end
    addr_phase(1'b1, HSIZE_WORD, 20'h00040);
    bus.HWDATA = 32'hCAFEF00D;
    tick();
    bus.HWDATA = 32'h0;
    n_cmp++;
    if ({bus.ahbsram_req, bus.ahbsram_addr, bus.ahbsram_wdata} !== {1'b1, 20'h00040, 32'hCAFEF00D}) begin
      $display("FAIL to_b2b_req: req/addr/wdata got %b %h %h want 1 00040 cafef00d",
               bus.ahbsram_req, bus.ahbsram_addr, bus.ahbsram_wdata);
      n_bad++;
    end
    tick();
    bus.sramahb_ack = 1'b1;
    tick();
    bus.sramahb_ack = 1'b0;
    n_cmp++;
    if ({bus.HREADYOUT, bus.HRESP} !== 3'b100) begin
      $display("FAIL to_b2b_done: got %b want 100", {bus.HREADYOUT, bus.HRESP});
      n_bad++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    addr_phase(1'b0, HSIZE_WORD, 20'h00050);
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_addr} !== {2'b10, 20'h0}) begin
      $display("FAIL rstmid_now: rdy/req/addr got %b %b %h want 1 0 00000",
               bus.HREADYOUT, bus.ahbsram_req, bus.ahbsram_addr);
      n_bad++;
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus.HREADYOUT, bus.ahbsram_req} !== 2'b10) begin
        $display("FAIL rstmid_after[%0d]: got %b want 10", i, {bus.HREADYOUT, bus.ahbsram_req});
        n_bad++;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    err_size[0] = HSIZE_HALF; err_addr[0] = 20'h00003;
    err_size[1] = HSIZE_BYTE; err_addr[1] = 20'h00800;
    err_size[2] = HSIZE_WORD; err_addr[2] = 20'h00002;
    err_size[3] = 3'b011;     err_addr[3] = 20'h00000;
    bus.HSEL          = 1'b0;
    bus.HREADYIN      = 1'b1;
    bus.HWRITE        = 1'b0;
    bus.HTRANS        = HTRANS_IDLE;
    bus.HSIZE         = 3'b000;
    bus.HADDR         = 20'h0;
    bus.HWDATA        = 32'h0;
    bus.sramahb_ack   = 1'b0;
    bus.sramahb_rdata = 32'h0;
    bus.BUSY          = 1'b0;
    rst               = 1'b1;
    test_reset();
    test_idle();
    test_write();
    test_read();
    test_errors();
    test_back_to_back();
    test_busy();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave_if.md
AHB_SRAM_SLAVE_IF -- requirements
Module: ahb_sram_slave_if

Interface
REQ-001 Parameter MEM_BYTES, default 2048: decoded SRAM size in bytes; HADDR >= MEM_BYTES is out of range.
REQ-002 Parameter ACK_TIMEOUT, default 15: cycles allowed in WAIT_ACK before an error response.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 HCLK  in  1  sole clock, rising edge.
REQ-005 HRESET  in  1  asynchronous, active-high reset.
REQ-006 HSEL, HREADYIN, HWRITE  in  1 each  AHB-Lite slave select, bus ready, direction.
REQ-007 HTRANS  in  2; HSIZE  in  3; HADDR  in  20; HWDATA  in  32  AHB-Lite address/data-phase inputs.
REQ-008 HREADYOUT  out  1; HRESP  out  2 (00 OKAY, 01 ERROR); HRDATA  out  32  AHB-Lite slave response.
REQ-009 ahbsram_req, ahbsram_write  out  1; ahbsram_size  out  3; ahbsram_addr  out  20; ahbsram_wdata  out  32  SRAM controller request.
REQ-010 sramahb_ack  in  1; sramahb_rdata  in  32; BUSY  in  1  SRAM controller response and init-busy.

Function
REQ-011 A valid address phase SHALL be HSEL & HREADYIN & HTRANS[1], sampled only in states IDLE, DONE and ERR2.
REQ-012 HTRANS IDLE/BUSY or HSEL=0 SHALL give a zero-wait OKAY with no SRAM request.
REQ-013 States: IDLE, WDATA, ISSUE, WAIT_ACK, DONE, ERR1, ERR2; encoding in shared package.
REQ-014 A valid phase SHALL be an error (go to ERR1, no SRAM request) when HSIZE>010, HSIZE=001 with HADDR[0]=1, HSIZE=010 with HADDR[1:0]!=00, or HADDR>=MEM_BYTES.
REQ-015 Otherwise HADDR, HSIZE and HWRITE SHALL be registered onto ahbsram_addr/size/write; write goes to WDATA, read goes to ISSUE.
REQ-016 WDATA: HREADYOUT=0; HWDATA registered into ahbsram_wdata at exit; next state ISSUE.
REQ-017 ISSUE: ahbsram_req = !BUSY, combinational from registered state; BUSY=1 holds ISSUE with HREADYOUT=0; BUSY=0 moves to WAIT_ACK.
REQ-018 ahbsram_req SHALL be high for exactly one cycle per transfer.
REQ-019 ahbsram_addr/size/write/wdata SHALL be held stable from ISSUE until the cycle after sramahb_ack.
REQ-020 WAIT_ACK: HREADYOUT=0; sramahb_ack=1 goes to DONE.
REQ-021 If ACK_TIMEOUT cycles elapse in WAIT_ACK without ack, the block SHALL go to ERR1; the counter clears on entry to WAIT_ACK.
REQ-022 DONE: HREADYOUT=1, HRESP=00; HRDATA = sramahb_rdata, which is valid in DONE for reads.
REQ-023 ERR1: HREADYOUT=0, HRESP=01. ERR2: HREADYOUT=1, HRESP=01. ERR1 always goes to ERR2.
REQ-024 DONE and ERR2 without a new valid phase SHALL go to IDLE; with a new valid phase, that phase SHALL be accepted per REQ-014/015 (back-to-back pipelining).
REQ-025 Latency from the address-phase edge: read DONE in cycle 3 (2 wait states); write DONE in cycle 4 (3 wait states), with BUSY=0 and ack one cycle after req.
REQ-026 IDLE: HREADYOUT=1, HRESP=00.

Reset
REQ-027 HRESET=1 SHALL asynchronously force state IDLE, HREADYOUT=1, HRESP=00, ahbsram_req=0, ahbsram_addr/size/write/wdata=0, and timeout counter=0.
REQ-028 Reset mid-transfer SHALL abandon the transfer; no req pulse SHALL be issued after deassertion without a new address phase.

Structure
REQ-029 Shared package: state encodings, HTRANS and HRESP constants, HSIZE byte/half/word constants.
REQ-030 One sub-module, ahb_sram_ack_timer: a loadable down-counter of width clog2(ACK_TIMEOUT+1) with an expire flag.

Verification
REQ-031 Word write to 0x00010, HWDATA=0xDEADBEEF -> req in cycle 2, wdata=0xDEADBEEF, size=010, DONE OKAY in cycle 4.
REQ-032 Word read of 0x00010 after REQ-031 -> req in cycle 1, HRDATA=0xDEADBEEF with HREADYOUT=1 in cycle 3.
REQ-033 Halfword at 0x00003, then 8-bit access to HADDR=0x00800 with MEM_BYTES=2048 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=01) each time, no req.
REQ-034 BUSY held high 5 cycles during a read -> HREADYOUT low throughout, req single pulse after BUSY falls, read completes OKAY.
REQ-035 Ack never returned -> ERR1 after 15 WAIT_ACK cycles, then ERR2; a back-to-back write accepted in ERR2 completes OKAY.
REQ-036 HRESET pulsed in WAIT_ACK -> immediately HREADYOUT=1, req=0; no spurious req afterwards.
